// File: rtl/port_seq_pkg.sv
// port_seq_pkg: shared types and constants for the port stimulus sequencer.
package port_seq_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LATENCY = 1;
    localparam logic [7:0] ERR_MAX = 8'd255;
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_DATA_W-1:0] exp;
    } cmd_t;
endpackage

// File: rtl/port_seq_fifo.sv
// port_seq_fifo: synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module port_seq_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/port_stimulus_sequencer.sv
// port_stimulus_sequencer: applies queued commands to a registered port DUT and
// returns the sampled output with a match flag and saturating mismatch count.
module port_stimulus_sequencer
    import port_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_expect,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_match,
    output logic [7:0]        err_count,
    output logic              busy,
    output logic [DATA_W-1:0] dut_input_reg_data,
    output logic              dut_reg_wire_input,
    input  logic [DATA_W-1:0] dut_output_reg_data
);
    localparam int CW = $clog2(LATENCY + 1);
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] exp_q;
    logic [2*DATA_W-1:0] head;
    logic full, empty, pop, sample, mismatch;
    port_seq_fifo #(.W(2 * DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(cmd_valid && cmd_ready),
        .wdata({cmd_data, cmd_expect}),
        .pop(pop),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    // Held low while reset is applied so every output reads 0 during reset.
    assign cmd_ready = !full && !reset;
    assign busy = (state != IDLE) || !empty;
    assign rsp_valid = state == RESPOND;
    assign sample = (state == WAIT) && (cnt == '0);
    assign mismatch = dut_output_reg_data != exp_q;
    always_comb begin
        pop = (state == IDLE) && !empty;
        next = pop ? WAIT : sample ? RESPOND : (rsp_valid && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            exp_q <= '0;
            dut_input_reg_data <= '0;
            dut_reg_wire_input <= 1'b0;
            rsp_data <= '0;
            rsp_match <= 1'b0;
            err_count <= '0;
        end else begin
            dut_reg_wire_input <= pop;
            if (pop) begin
                dut_input_reg_data <= head[2*DATA_W-1:DATA_W];
                exp_q <= head[DATA_W-1:0];
                cnt <= CW'(LATENCY);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (sample) begin
                rsp_data <= dut_output_reg_data;
                rsp_match <= !mismatch;
                if (mismatch && err_count != ERR_MAX) err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: doc/port_stimulus_sequencer.md
# port_stimulus_sequencer

Drives the input side of a registered keyword-port DUT (8-bit `input_reg_data` path with `reg_wire_input` strobe) and captures its registered output after a fixed latency. It is the transmitting and checking end of that port interface. Commands are queued with an expected value, applied one at a time, and returned as responses with a match flag and a saturating mismatch count. It sits between the wrapper-generator testbench harness and the generated wrapper under test.

## Interface
- `DATA_W`, 8: width of the data and expect fields.
- `FIFO_DEPTH`, 4: command queue depth; power of two, ≥2.
- `LATENCY`, 1: DUT register stages, from driven input to valid output; ≥1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  queue not full.
- `cmd_data`  in  DATA_W  value to drive into the DUT.
- `cmd_expect`  in  DATA_W  expected DUT output.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DATA_W  sampled DUT output.
- `rsp_match`  out  1  `rsp_data == expect`.
- `err_count`  out  8  saturating count of mismatches.
- `busy`  out  1  FSM not in IDLE, or queue non-empty.
- `dut_input_reg_data`  out  DATA_W  drives DUT `input_reg_data`.
- `dut_reg_wire_input`  out  1  one-cycle apply strobe to DUT `reg_wire_input`.
- `dut_output_reg_data`  in  DATA_W  DUT registered output.

## Operation
- Queue:
  - FIFO of {data, expect}.
  - Push when `cmd_valid && cmd_ready`; `cmd_ready = !full`.
  - A push offered while full is ignored. No same-cycle push-through when full.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - If the queue is non-empty, pop.
  - Register `dut_input_reg_data <= data`, latch expect, `cnt <= LATENCY`, go to WAIT.
- WAIT:
  - `dut_reg_wire_input` is 1 only in the first WAIT cycle.
  - While `cnt != 0`, decrement.
  - When `cnt == 0`: sample `dut_output_reg_data` into `rsp_data`, set `rsp_match`, go to RESPOND.
  - On mismatch, increment `err_count`; it saturates at 255.
- RESPOND:
  - `rsp_valid = 1`; `rsp_data` and `rsp_match` are stable until `rsp_ready`.
  - On handshake, return to IDLE.
- `dut_input_reg_data` holds its last value between commands.
- Pushes continue during WAIT and RESPOND.
- `rsp_ready` asserted outside RESPOND has no effect.
- Reset, including mid-operation:
  - Queue emptied, FSM to IDLE.
  - All outputs 0; `cmd_ready = 1` once reset deasserts.
  - An in-flight command is discarded without a response.

## Timing
- Command accepted in cycle A:
  - Pop in A+1 (IDLE).
  - `dut_input_reg_data` and strobe visible in A+2.
  - Sample at the end of A+2+LATENCY.
  - `rsp_valid` high from A+3+LATENCY.
- For LATENCY=1, `rsp_valid` rises 4 cycles after the command handshake.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle.
- The earliest pop of the next command is the cycle after the response handshake. Throughput is one command per LATENCY+3 cycles.
- `err_count` updates on the same edge that sets `rsp_valid`.
- Queue full/empty and `busy` are registered state; `cmd_ready` is combinational from the full flag.

## Structure
- Package `port_seq_pkg`:
  - FSM state enum (IDLE/WAIT/RESPOND).
  - Command struct {data, expect}.
  - Default width constants.
  - `ERR_MAX` = 255.
- Sub-module `port_seq_fifo`: parameterised sync FIFO, with full/empty and wrap-around pointers carrying one extra bit.
- Top level: FSM, latency counter, sample/compare and error counter.

## Test plan
- Single command, model DUT with LATENCY=1 (register): push data=0xA5, expect=0xA5.
  - `dut_reg_wire_input` pulses in A+2; `rsp_valid` in A+4.
  - `rsp_data`=0xA5, `rsp_match`=1, `err_count`=0.
- Mismatch: push data=0x3C, expect=0x3D.
  - `rsp_data`=0x3C, `rsp_match`=0, `err_count`=1.
  - 300 mismatching commands leave `err_count`=255.
- Full queue: hold `rsp_ready`=0 and push 6 commands back-to-back.
  - 1 is popped and 4 are queued.
  - `cmd_ready` falls after the 5th accept; the 6th is not accepted until a pop.
- Backpressure: `rsp_ready`=0 for 10 cycles.
  - `rsp_valid`, `rsp_data` and `rsp_match` are held.
  - No further DUT strobe until the handshake.
- LATENCY=3 build, 3-stage DUT model: push 0x11, 0x22, 0x33.
  - All match.
  - Responses spaced 6 cycles apart with `rsp_ready`=1.
- Reset asserted during WAIT with 2 commands queued:
  - Outputs go to 0 immediately, with no response.
  - After release, `busy`=0, and a new push of 0x5A completes normally.
